sram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port line-buffer SRAM (1-cycle synchronous read) between the scaler datapath and a second client such as a host readback or test-pattern port. It grants at most one access per cycle, using round-robin or fixed priority, and drives the RAM command. It returns read data to the issuing port with a fixed latency and a valid strobe, and keeps a saturating stall counter for bandwidth debug. It sits between the scaler controller and one single_port_ram instance; one arbiter is instantiated per RAM bank.

---
 rtl/sram_port_arbiter.sv | 114 +++++++++++
 tb/tb_sram_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for one single-port line-buffer SRAM: grants one access per cycle,
// returns read data to the issuing port two cycles after accept, counts stall cycles.
module sram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 30,
  parameter int unsigned RR_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_din0,
  input  logic [DATA_WIDTH-1:0] i_din1,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_cs,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_din,
  input  logic [DATA_WIDTH-1:0] i_dout,
  input  logic                  i_stall_clr,
  output logic [15:0]           o_stall_cnt
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  port_e                 last_win_q, last_win_d;
  logic                  rd_vld_q;
  port_e                 rd_port_q;
  logic                  rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic                  conflict;
  logic                  stall;

  assign conflict = i_req0 & i_req1;

  // Grants are gated by rstn so nothing reaches the RAM while reset is held.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (rstn) begin
      if (conflict) begin
        if ((RR_EN != 0) && (last_win_q == PORT0)) o_gnt1 = 1'b1;
        else                                       o_gnt0 = 1'b1;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  always_comb begin
    o_cs   = o_gnt0 | o_gnt1;
    o_we   = 1'b0;
    o_addr = '0;
    o_din  = '0;
    if (o_gnt1) begin
      o_we   = i_we1;
      o_addr = i_addr1;
      o_din  = i_din1;
    end else if (o_gnt0) begin
      o_we   = i_we0;
      o_addr = i_addr0;
      o_din  = i_din0;
    end
  end

  always_comb begin
    last_win_d = last_win_q;
    if (conflict && rstn) last_win_d = o_gnt1 ? PORT1 : PORT0;
    stall       = (i_req0 & ~o_gnt0) | (i_req1 & ~o_gnt1);
    stall_cnt_d = stall_cnt_q;
    if (i_stall_clr)                        stall_cnt_d = '0;
    else if (stall && stall_cnt_q != '1)    stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_win_q  <= PORT1;
      rd_vld_q    <= 1'b0;
      rd_port_q   <= PORT0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      last_win_q  <= last_win_d;
      rd_vld_q    <= o_cs & ~o_we;
      rd_port_q   <= o_gnt1 ? PORT1 : PORT0;
      rvalid0_q   <= rd_vld_q & (rd_port_q == PORT0);
      rvalid1_q   <= rd_vld_q & (rd_port_q == PORT1);
      if (rd_vld_q && rd_port_q == PORT0) rdata0_q <= i_dout;
      if (rd_vld_q && rd_port_q == PORT1) rdata1_q <= i_dout;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_rvalid0   = rvalid0_q;
  assign o_rvalid1   = rvalid1_q;
  assign o_rdata0    = rdata0_q;
  assign o_rdata1    = rdata1_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share the same
// request stimulus, each driving its own behavioural 64x30 RAM.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req1, we0, we1, stall_clr;
  logic [5:0]  addr0, addr1;
  logic [29:0] din0, din1;

  logic        gnt0_r, gnt1_r, rv0_r, rv1_r, cs_r, we_r;
  logic [29:0] rd0_r, rd1_r, din_r, dout_r;
  logic [5:0]  addr_r;
  logic [15:0] cnt_r;
  logic        gnt0_f, gnt1_f, rv0_f, rv1_f, cs_f, we_f;
  logic [29:0] rd0_f, rd1_f, din_f, dout_f;
  logic [5:0]  addr_f;
  logic [15:0] cnt_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(30), .RR_EN(1)) u_rr (
    .clk(clk), .rstn(rstn),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_din0(din0), .i_din1(din1),
    .o_gnt0(gnt0_r), .o_gnt1(gnt1_r), .o_rvalid0(rv0_r), .o_rvalid1(rv1_r),
    .o_rdata0(rd0_r), .o_rdata1(rd1_r), .o_cs(cs_r), .o_we(we_r),
    .o_addr(addr_r), .o_din(din_r), .i_dout(dout_r),
    .i_stall_clr(stall_clr), .o_stall_cnt(cnt_r)
  );

  sram_port_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(30), .RR_EN(0)) u_fp (
    .clk(clk), .rstn(rstn),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_din0(din0), .i_din1(din1),
    .o_gnt0(gnt0_f), .o_gnt1(gnt1_f), .o_rvalid0(rv0_f), .o_rvalid1(rv1_f),
    .o_rdata0(rd0_f), .o_rdata1(rd1_f), .o_cs(cs_f), .o_we(we_f),
    .o_addr(addr_f), .o_din(din_f), .i_dout(dout_f),
    .i_stall_clr(stall_clr), .o_stall_cnt(cnt_f)
  );

  function automatic logic [29:0] pat(input int unsigned a);
    return 30'h2000000 + 30'(a);
  endfunction

  logic [29:0] mem_r [64];
  logic [29:0] mem_f [64];

  initial begin
    for (int unsigned a = 0; a < 64; a++) begin
      mem_r[a] = pat(a);
      mem_f[a] = pat(a);
    end
  end

  always @(posedge clk) begin
    if (cs_r) begin
      if (we_r) mem_r[addr_r] <= din_r;
      else      dout_r        <= mem_r[addr_r];
    end
    if (cs_f) begin
      if (we_f) mem_f[addr_f] <= din_f;
      else      dout_f        <= mem_f[addr_f];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    rstn = 1'b0;
    idle();
    @(negedge clk);
    next_cycle();
    rstn = 1'b1;
  endtask

  typedef struct {
    logic       r0, w0;
    logic [5:0] a0;
    logic       r1, w1;
    logic [5:0] a1;
    logic       g0r, g1r, g0f, g1f;
    logic [5:0] ar, af;
  } vec_t;

  vec_t vecs [10];

  int unsigned p0a, p1a;
  logic        e_rd [11];
  logic        e_g0 [11];
  logic [29:0] e_dat [11];
  logic        eg0, eg1;

  initial begin
    vecs[0] = '{1'b0,1'b0,6'd0, 1'b0,1'b0,6'd0,  1'b0,1'b0,1'b0,1'b0, 6'd0, 6'd0};
    vecs[1] = '{1'b1,1'b1,6'd5, 1'b0,1'b0,6'd0,  1'b1,1'b0,1'b1,1'b0, 6'd5, 6'd5};
    vecs[2] = '{1'b0,1'b0,6'd0, 1'b1,1'b0,6'd7,  1'b0,1'b1,1'b0,1'b1, 6'd7, 6'd7};
    vecs[3] = '{1'b1,1'b0,6'd1, 1'b1,1'b0,6'd2,  1'b1,1'b0,1'b1,1'b0, 6'd1, 6'd1};
    vecs[4] = '{1'b1,1'b0,6'd3, 1'b1,1'b0,6'd4,  1'b0,1'b1,1'b1,1'b0, 6'd4, 6'd3};
    vecs[5] = '{1'b1,1'b0,6'd3, 1'b1,1'b0,6'd4,  1'b1,1'b0,1'b1,1'b0, 6'd3, 6'd3};
    vecs[6] = '{1'b1,1'b0,6'd6, 1'b0,1'b0,6'd0,  1'b1,1'b0,1'b1,1'b0, 6'd6, 6'd6};
    vecs[7] = '{1'b1,1'b0,6'd3, 1'b1,1'b0,6'd4,  1'b0,1'b1,1'b1,1'b0, 6'd4, 6'd3};
    vecs[8] = '{1'b1,1'b0,6'd9, 1'b1,1'b1,6'd10, 1'b1,1'b0,1'b1,1'b0, 6'd9, 6'd9};
    vecs[9] = '{1'b0,1'b0,6'd0, 1'b1,1'b1,6'd10, 1'b0,1'b1,1'b0,1'b1, 6'd10,6'd10};

    rstn = 1'b1;
    stall_clr = 1'b0;
    idle();
    #2;
    rstn = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 6'd3; addr1 = 6'd4;
    #1;
    check("rst_gnt0_r", 32'(gnt0_r), 32'd0);
    check("rst_gnt1_r", 32'(gnt1_r), 32'd0);
    check("rst_cs_r",   32'(cs_r),   32'd0);
    check("rst_gnt0_f", 32'(gnt0_f), 32'd0);
    check("rst_cs_f",   32'(cs_f),   32'd0);
    check("rst_rv_r",   32'({rv0_r, rv1_r}), 32'd0);
    check("rst_rdata_r", 32'(rd0_r | rd1_r), 32'd0);
    check("rst_cnt_r",  32'(cnt_r), 32'd0);
    check("rst_cnt_f",  32'(cnt_f), 32'd0);
    @(negedge clk);
    next_cycle();
    idle();
    rstn = 1'b1;

    // Arbitration table from reset: last_win starts at port 1.
    din0 = 30'h1234567;
    din1 = 30'h0ABCDEF;
    for (int unsigned i = 0; i < 10; i++) begin
      req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1;
      @(negedge clk);
      check($sformatf("vec%0d_gnt0_r", i), 32'(gnt0_r), 32'(vecs[i].g0r));
      check($sformatf("vec%0d_gnt1_r", i), 32'(gnt1_r), 32'(vecs[i].g1r));
      check($sformatf("vec%0d_gnt0_f", i), 32'(gnt0_f), 32'(vecs[i].g0f));
      check($sformatf("vec%0d_gnt1_f", i), 32'(gnt1_f), 32'(vecs[i].g1f));
      check($sformatf("vec%0d_cs_r", i),   32'(cs_r),   32'(vecs[i].g0r | vecs[i].g1r));
      check($sformatf("vec%0d_we_r", i),   32'(we_r),
            32'(vecs[i].g1r ? vecs[i].w1 : (vecs[i].g0r ? vecs[i].w0 : 1'b0)));
      check($sformatf("vec%0d_addr_r", i), 32'(addr_r), 32'(vecs[i].ar));
      check($sformatf("vec%0d_addr_f", i), 32'(addr_f), 32'(vecs[i].af));
      next_cycle();
    end

    // Port 0 write then read of addr 5.
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; din0 = 30'h1234567;
    @(negedge clk);
    check("a_wr_gnt0", 32'(gnt0_r), 32'd1);
    check("a_wr_we",   32'(we_r),   32'd1);
    check("a_wr_din",  32'(din_r),  32'h1234567);
    next_cycle();
    we0 = 1'b0; din0 = '0;
    @(negedge clk);
    check("a_rd_gnt0", 32'(gnt0_r), 32'd1);
    check("a_rd_we",   32'(we_r),   32'd0);
    check("a_rd_addr", 32'(addr_r), 32'd5);
    next_cycle();
    idle();
    @(negedge clk);
    check("a_n1_rv0", 32'(rv0_r), 32'd0);
    next_cycle();
    @(negedge clk);
    check("a_n2_rv0",   32'(rv0_r), 32'd1);
    check("a_n2_rdata", 32'(rd0_r), 32'h1234567);
    check("a_n2_rv1",   32'(rv1_r), 32'd0);
    next_cycle();
    @(negedge clk);
    check("a_n3_rv0",   32'(rv0_r), 32'd0);
    check("a_n3_hold",  32'(rd0_r), 32'h1234567);
    check("a_n3_rv1",   32'(rv1_r), 32'd0);

    // Continuous dual-port reads: round-robin alternation and tagged returns.
    do_reset();
    p0a = 16; p1a = 32;
    for (int unsigned c = 0; c < 11; c++) begin
      req0 = (c < 8); req1 = (c < 9);
      addr0 = 6'(p0a); addr1 = 6'(p1a);
      eg0 = req0 && (!req1 || (c % 2 == 0));
      eg1 = req1 && !eg0;
      e_rd[c]  = eg0 | eg1;
      e_g0[c]  = eg0;
      e_dat[c] = pat(eg0 ? p0a : p1a);
      @(negedge clk);
      check($sformatf("b%0d_gnt0_r", c), 32'(gnt0_r), 32'(eg0));
      check($sformatf("b%0d_gnt1_r", c), 32'(gnt1_r), 32'(eg1));
      check($sformatf("b%0d_gnt0_f", c), 32'(gnt0_f), 32'(req0));
      check($sformatf("b%0d_gnt1_f", c), 32'(gnt1_f), 32'(req1 & ~req0));
      if (c >= 2) begin
        check($sformatf("b%0d_rv0", c), 32'(rv0_r), 32'(e_rd[c-2] & e_g0[c-2]));
        check($sformatf("b%0d_rv1", c), 32'(rv1_r), 32'(e_rd[c-2] & ~e_g0[c-2]));
        if (e_rd[c-2]) begin
          if (e_g0[c-2]) check($sformatf("b%0d_rd0", c), 32'(rd0_r), 32'(e_dat[c-2]));
          else           check($sformatf("b%0d_rd1", c), 32'(rd1_r), 32'(e_dat[c-2]));
        end
      end
      if (eg0) p0a++;
      if (eg1) p1a++;
      next_cycle();
    end
    @(negedge clk);
    check("b_cnt_r", 32'(cnt_r), 32'd8);
    check("b_cnt_f", 32'(cnt_f), 32'd8);

    // Same-address conflict: port 0 reads old data, re-read sees port 1's write.
    do_reset();
    req0 = 1'b1; addr0 = 6'd63;
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd63; din1 = 30'h3FFFFFFF;
    @(negedge clk);
    check("c0_gnt0", 32'(gnt0_r), 32'd1);
    check("c0_gnt1", 32'(gnt1_r), 32'd0);
    check("c0_we",   32'(we_r),   32'd0);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    check("c1_gnt1", 32'(gnt1_r), 32'd1);
    check("c1_we",   32'(we_r),   32'd1);
    check("c1_din",  32'(din_r),  32'h3FFFFFFF);
    next_cycle();
    idle();
    req0 = 1'b1; addr0 = 6'd63;
    @(negedge clk);
    check("c2_gnt0",  32'(gnt0_r), 32'd1);
    check("c2_rv0",   32'(rv0_r),  32'd1);
    check("c2_old",   32'(rd0_r),  32'(pat(63)));
    next_cycle();
    idle();
    @(negedge clk);
    check("c3_rv0", 32'(rv0_r), 32'd0);
    next_cycle();
    @(negedge clk);
    check("c4_rv0", 32'(rv0_r), 32'd1);
    check("c4_new", 32'(rd0_r), 32'h3FFFFFFF);
    check("c4_rd1_held", 32'(rd1_r), 32'd0);

    // Reset while a read is in flight.
    next_cycle();
    req0 = 1'b1; addr0 = 6'd20;
    @(negedge clk);
    check("d_gnt0", 32'(gnt0_r), 32'd1);
    next_cycle();
    addr0 = 6'd21;
    rstn = 1'b0;
    #1;
    check("d_rst_gnt0",  32'(gnt0_r), 32'd0);
    check("d_rst_cs",    32'(cs_r),   32'd0);
    check("d_rst_addr",  32'(addr_r), 32'd0);
    check("d_rst_rd0",   32'(rd0_r),  32'd0);
    check("d_rst_rv0",   32'(rv0_r),  32'd0);
    check("d_rst_cnt",   32'(cnt_r),  32'd0);
    @(negedge clk);
    next_cycle();
    rstn = 1'b1;
    idle();
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("d_post%0d_rv0", k), 32'(rv0_r), 32'd0);
      next_cycle();
    end

    // Stall counter saturation and clear priority.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 6'd1; addr1 = 6'd2;
    @(negedge clk);
    check("e_cnt0", 32'(cnt_f), 32'd0);
    repeat (65534) next_cycle();
    @(negedge clk);
    check("e_cnt_fffe", 32'(cnt_f), 32'hFFFE);
    next_cycle();
    @(negedge clk);
    check("e_cnt_ffff", 32'(cnt_f), 32'hFFFF);
    repeat (3) next_cycle();
    @(negedge clk);
    check("e_cnt_sat_f", 32'(cnt_f), 32'hFFFF);
    check("e_cnt_sat_r", 32'(cnt_r), 32'hFFFF);
    check("e_gnt1_f",    32'(gnt1_f), 32'd0);
    next_cycle();
    stall_clr = 1'b1;
    @(negedge clk);
    next_cycle();
    stall_clr = 1'b0;
    @(negedge clk);
    check("e_clr_f", 32'(cnt_f), 32'd0);
    check("e_clr_r", 32'(cnt_r), 32'd0);
    next_cycle();
    @(negedge clk);
    check("e_after_clr", 32'(cnt_f), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
